// File: rtl/he_lut_gen.sv
// Histogram-equalisation LUT generator: multi-channel histogram, CDF, equalisation map,
// then the NUM_BINS-entry LUT streamed out over valid/ready.
module he_lut_gen #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 21,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CWIDTH-1:0]        total_pix,
  input  logic [NUM_CH-1:0]        pix_valid,
  input  logic [NUM_CH*DWIDTH-1:0] pix_data,
  output logic                     pix_ready,
  output logic                     lut_valid,
  input  logic                     lut_ready,
  output logic [DWIDTH-1:0]        lut_addr,
  output logic [DWIDTH-1:0]        lut_data,
  output logic                     lut_last,
  output logic                     done,
  output logic                     busy,
  output logic [5:0]               state
);

  localparam int NUM_BINS = 2 ** DWIDTH;
  localparam int MW       = CWIDTH + DWIDTH;
  localparam logic [DWIDTH-1:0] LAST_BIN = {DWIDTH{1'b1}};

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CLEAR = 6'b000010,
    S_HIST  = 6'b000100,
    S_CDF   = 6'b001000,
    S_MAP   = 6'b010000,
    S_OUT   = 6'b100000
  } state_t;

  state_t             state_r;
  logic [CWIDTH-1:0]  total_r;
  logic [CWIDTH-1:0]  cnt_r;
  logic [CWIDTH-1:0]  cdf_acc_r;
  logic [DWIDTH-1:0]  idx_r;
  logic [CWIDTH-1:0]  hist_r [NUM_BINS];
  logic [DWIDTH-1:0]  lut_r  [NUM_BINS];

  logic [CWIDTH-1:0]  remain_s;
  logic [CWIDTH-1:0]  cnt_next_s;
  logic [CWIDTH-1:0]  cdf_sum_s;
  logic [DWIDTH-1:0]  next_addr_s;
  logic [2:0]         n_take_s;
  logic [NUM_CH-1:0]  take_s;
  logic [NUM_CH-1:0]  first_s;
  logic [2:0]         inc_s     [NUM_CH];
  logic [DWIDTH-1:0]  ch_data_s [NUM_CH];

  // Rounded, saturated equalisation value for one CDF entry.
  function automatic logic [DWIDTH-1:0] eq_value(input logic [CWIDTH-1:0] cdf,
                                                 input logic [CWIDTH-1:0] total);
    logic [MW-1:0] num;
    logic [MW-1:0] quo;
    num = MW'(cdf) * MW'(NUM_BINS - 1) + MW'(total >> 1'b1);
    quo = num / MW'(total);
    if (quo > MW'(NUM_BINS - 1)) begin
      eq_value = LAST_BIN;
    end else begin
      eq_value = quo[DWIDTH-1:0];
    end
  endfunction

  assign state       = state_r;
  assign cnt_next_s  = cnt_r + CWIDTH'(n_take_s);
  assign cdf_sum_s   = cdf_acc_r + hist_r[idx_r];
  assign next_addr_s = lut_addr + 1'b1;

  // Accept valid channels in ascending order until the frame's pixel budget is used up.
  always_comb begin
    remain_s = total_r - cnt_r;
    n_take_s = 3'd0;
    take_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data_s[k] = pix_data[k*DWIDTH +: DWIDTH];
      if (pix_ready && pix_valid[k] && (CWIDTH'(n_take_s) < remain_s)) begin
        take_s[k] = 1'b1;
        n_take_s  = n_take_s + 3'd1;
      end else begin
        take_s[k] = 1'b0;
      end
    end
  end

  // The first accepted channel of each value carries the summed increment, so collisions add up.
  always_comb begin
    first_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      inc_s[k]   = 3'd0;
      first_s[k] = take_s[k];
      for (int j = 0; j < NUM_CH; j++) begin
        inc_s[k]   = inc_s[k] + {2'b00, (take_s[j] && (ch_data_s[j] == ch_data_s[k]))};
        first_s[k] = first_s[k] & ~((take_s[j] && (ch_data_s[j] == ch_data_s[k])) && (j < k));
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      total_r   <= '0;
      cnt_r     <= '0;
      cdf_acc_r <= '0;
      idx_r     <= '0;
      pix_ready <= 1'b0;
      lut_valid <= 1'b0;
      lut_addr  <= '0;
      lut_data  <= '0;
      lut_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && (total_pix != '0)) begin
            total_r <= total_pix;
            cnt_r   <= '0;
            idx_r   <= '0;
            busy    <= 1'b1;
            state_r <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          idx_r <= idx_r + 1'b1;
          if (idx_r == LAST_BIN) begin
            pix_ready <= 1'b1;
            state_r   <= S_HIST;
          end
        end
        S_HIST: begin
          cnt_r <= cnt_next_s;
          if (cnt_next_s == total_r) begin
            pix_ready <= 1'b0;
            cdf_acc_r <= '0;
            state_r   <= S_CDF;
          end
        end
        S_CDF: begin
          idx_r     <= idx_r + 1'b1;
          cdf_acc_r <= cdf_sum_s;
          if (idx_r == LAST_BIN) begin
            state_r <= S_MAP;
          end
        end
        S_MAP: begin
          idx_r <= idx_r + 1'b1;
          if (idx_r == LAST_BIN) begin
            lut_valid <= 1'b1;
            lut_addr  <= '0;
            lut_data  <= lut_r[0];
            lut_last  <= 1'b0;
            state_r   <= S_OUT;
          end
        end
        S_OUT: begin
          if (lut_ready) begin
            if (lut_last) begin
              lut_valid <= 1'b0;
              lut_last  <= 1'b0;
              lut_addr  <= '0;
              lut_data  <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_r   <= S_IDLE;
            end else begin
              lut_addr <= next_addr_s;
              lut_data <= lut_r[next_addr_s];
              lut_last <= (next_addr_s == LAST_BIN);
            end
          end
        end
        default: begin
          pix_ready <= 1'b0;
          lut_valid <= 1'b0;
          lut_last  <= 1'b0;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  // Histogram/CDF and LUT storage; CLEAR reinitialises it every frame so it needs no reset.
  always_ff @(posedge clk) begin
    case (state_r)
      S_CLEAR: hist_r[idx_r] <= '0;
      S_HIST: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (first_s[k]) begin
            hist_r[ch_data_s[k]] <= hist_r[ch_data_s[k]] + CWIDTH'(inc_s[k]);
          end
        end
      end
      S_CDF:   hist_r[idx_r] <= cdf_sum_s;
      S_MAP:   lut_r[idx_r]  <= eq_value(hist_r[idx_r], total_r);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_he_lut_gen.sv
// Self-checking bench for he_lut_gen: directed scenarios plus randomized frames against a
// histogram/CDF/LUT reference model computed with plain integer arithmetic.
module tb_he_lut_gen;

  localparam int DW  = 8;
  localparam int CW  = 21;
  localparam int NCH = 2;
  localparam int NB  = 256;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CW-1:0]     total_pix;
  logic [NCH-1:0]    pix_valid;
  logic [NCH*DW-1:0] pix_data;
  logic              pix_ready;
  logic              lut_valid;
  logic              lut_ready;
  logic [DW-1:0]     lut_addr;
  logic [DW-1:0]     lut_data;
  logic              lut_last;
  logic              done;
  logic              busy;
  logic [5:0]        state;

  he_lut_gen #(.DWIDTH(DW), .CWIDTH(CW), .NUM_CH(NCH)) dut (
    .clk(clk), .reset(reset), .start(start), .total_pix(total_pix),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .lut_valid(lut_valid), .lut_ready(lut_ready), .lut_addr(lut_addr),
    .lut_data(lut_data), .lut_last(lut_last), .done(done), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NCH-1:0]    sv_q[$];
  logic [NCH*DW-1:0] sd_q[$];
  int                acc_q[$];
  int exp_lut[NB];
  int got_lut[NB];
  int seen[NB];
  int done_cnt, stall_err, order_err, last_err, handshakes, hist_cycles, latency;
  bit hist_to, out_to;
  logic post_done, post_valid, post_busy;
  logic [5:0] post_state, cdf_state;

  // Reference: histogram of accepted pixels, running CDF, rounded and saturated scaling.
  task automatic build_model(input int total);
    int hist[NB];
    longint cdf;
    longint q;
    foreach (hist[b]) hist[b] = 0;
    foreach (acc_q[i]) hist[acc_q[i]]++;
    cdf = 0;
    for (int b = 0; b < NB; b++) begin
      cdf += hist[b];
      q = (cdf * 255 + total / 2) / total;
      exp_lut[b] = (q > 255) ? 255 : int'(q);
    end
  endtask

  task automatic push_ramp();
    logic [DW-1:0] lo, hi;
    sv_q.delete();
    sd_q.delete();
    for (int c = 0; c < 128; c++) begin
      lo = DW'(2 * c);
      hi = DW'(2 * c + 1);
      sv_q.push_back(2'b11);
      sd_q.push_back({hi, lo});
    end
  endtask

  task automatic run_frame(input int total, input int ready_mode, input bit start_in_cdf);
    int w, p, exp_addr, remaining;
    bit fin, prev_stall, r;
    logic v, l, pl;
    logic [DW-1:0] a, d, pa, pd;
    logic [NCH-1:0] cv;
    logic [NCH*DW-1:0] cd;
    acc_q.delete();
    hist_to = 1'b0; out_to = 1'b0;
    done_cnt = 0; stall_err = 0; order_err = 0; last_err = 0; handshakes = 0; hist_cycles = 0;
    post_done = 1'b0; post_valid = 1'b1; post_busy = 1'b1; post_state = 6'b0;
    foreach (seen[i]) begin seen[i] = 0; got_lut[i] = -1; end
    @(negedge clk); start = 1'b1; total_pix = CW'(total);
    @(negedge clk); start = 1'b0; total_pix = CW'($urandom); latency = 1;
    w = 0;
    while (!pix_ready && w < 400) begin @(negedge clk); latency++; w++; end
    if (!pix_ready) begin hist_to = 1'b1; return; end
    while (pix_ready && hist_cycles < 3000) begin
      if (sv_q.size() > 0) begin cv = sv_q.pop_front(); cd = sd_q.pop_front(); end
      else begin cv = '0; cd = '0; end
      pix_valid = cv; pix_data = cd;
      remaining = total - acc_q.size();
      for (int k = 0; k < NCH; k++) begin
        if (cv[k] && remaining > 0) begin
          acc_q.push_back(int'(cd[k*DW +: DW]));
          remaining--;
        end
      end
      hist_cycles++;
      @(negedge clk); latency++;
    end
    pix_valid = '0;
    if (pix_ready) begin hist_to = 1'b1; return; end
    cdf_state = state;
    if (start_in_cdf) begin
      start = 1'b1; total_pix = CW'(7);
      @(negedge clk); latency++;
      start = 1'b0;
    end
    w = 0;
    while (!lut_valid && w < 1000) begin @(negedge clk); latency++; w++; end
    if (!lut_valid) begin out_to = 1'b1; return; end
    build_model(total);
    p = 0; exp_addr = 0; fin = 1'b0; prev_stall = 1'b0; w = 0;
    pa = '0; pd = '0; pl = 1'b0;
    while (!fin && w < 3000) begin
      v = lut_valid; a = lut_addr; d = lut_data; l = lut_last;
      done_cnt += int'(done);
      if (prev_stall && (v !== 1'b1 || a !== pa || d !== pd || l !== pl)) stall_err++;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ((p % 4) == 0) || ((p % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      p++;
      lut_ready = r;
      if (v && (l !== (a == 8'd255))) last_err++;
      if (v && r) begin
        handshakes++;
        if (a !== DW'(exp_addr)) order_err++;
        seen[a]++;
        got_lut[a] = int'(d);
        exp_addr++;
        if (l) fin = 1'b1;
      end
      prev_stall = v && !r;
      pa = a; pd = d; pl = l;
      @(negedge clk); w++;
    end
    lut_ready = 1'b0;
    if (!fin) begin out_to = 1'b1; return; end
    post_done = done; post_valid = lut_valid; post_busy = busy; post_state = state;
    done_cnt += int'(done);
    @(negedge clk); done_cnt += int'(done);
    @(negedge clk); done_cnt += int'(done);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL reset_state: got %b expected 000001", state);
    end
    n_checks++;
    if ({pix_ready, lut_valid, lut_last, done, busy, lut_addr, lut_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy%b v%b l%b d%b b%b a%0d dat%0d expected all 0",
               pix_ready, lut_valid, lut_last, done, busy, lut_addr, lut_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    int errs, fb;
    push_ramp();
    run_frame(256, 0, 1'b0);
    n_checks++;
    if (hist_to || out_to) begin n_fail++; $display("FAIL ramp_timeout: hist %0d out %0d expected 0 0", hist_to, out_to); end
    n_checks++;
    if (hist_cycles != 128) begin n_fail++; $display("FAIL ramp_hist_cycles: got %0d expected 128", hist_cycles); end
    n_checks++;
    if (latency != 897) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 897", latency); end
    n_checks++;
    if (got_lut[0] != 1 || got_lut[127] != 128 || got_lut[255] != 255) begin
      n_fail++; $display("FAIL ramp_points: got %0d/%0d/%0d expected 1/128/255", got_lut[0], got_lut[127], got_lut[255]);
    end
    errs = 0; fb = 0;
    for (int b = 0; b < NB; b++) if (got_lut[b] != exp_lut[b]) begin if (errs == 0) fb = b; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL ramp_lut: bin %0d got %0d expected %0d (%0d differ)", fb, got_lut[fb], exp_lut[fb], errs); end
    n_checks++;
    if (handshakes != 256 || done_cnt != 1) begin n_fail++; $display("FAIL ramp_handshakes: got %0d hs %0d done expected 256 hs 1 done", handshakes, done_cnt); end
    n_checks++;
    if ({post_done, post_valid, post_busy, post_state} !== {1'b1, 1'b0, 1'b0, 6'b000001}) begin
      n_fail++; $display("FAIL ramp_exit: got done%b v%b busy%b st%b expected done1 v0 busy0 st000001", post_done, post_valid, post_busy, post_state);
    end
  endtask

  task automatic test_collision();
    int errs, fb;
    sv_q.delete(); sd_q.delete();
    for (int c = 0; c < 8; c++) begin sv_q.push_back(2'b11); sd_q.push_back({8'd100, 8'd100}); end
    run_frame(16, 0, 1'b0);
    n_checks++;
    if (hist_to || out_to || hist_cycles != 8) begin n_fail++; $display("FAIL coll_flow: timeouts %0d/%0d cycles %0d expected 0/0 8", hist_to, out_to, hist_cycles); end
    n_checks++;
    if (got_lut[0] != 0 || got_lut[99] != 0 || got_lut[100] != 255 || got_lut[255] != 255) begin
      n_fail++; $display("FAIL coll_points: got %0d/%0d/%0d/%0d expected 0/0/255/255", got_lut[0], got_lut[99], got_lut[100], got_lut[255]);
    end
    errs = 0; fb = 0;
    for (int b = 0; b < NB; b++) if (got_lut[b] != exp_lut[b]) begin if (errs == 0) fb = b; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL coll_lut: bin %0d got %0d expected %0d", fb, got_lut[fb], exp_lut[fb]); end
  endtask

  task automatic test_overrun();
    sv_q.delete(); sd_q.delete();
    sv_q.push_back(2'b11); sd_q.push_back({8'd20, 8'd10});
    sv_q.push_back(2'b11); sd_q.push_back({8'd40, 8'd30});
    sv_q.push_back(2'b11); sd_q.push_back({8'd60, 8'd50});
    sv_q.push_back(2'b11); sd_q.push_back({8'd80, 8'd70});
    run_frame(5, 0, 1'b0);
    n_checks++;
    if (hist_to || out_to || hist_cycles != 3) begin n_fail++; $display("FAIL ovr_flow: timeouts %0d/%0d cycles %0d expected 0/0 3", hist_to, out_to, hist_cycles); end
    n_checks++;
    if (got_lut[10] != 51 || got_lut[39] != 153 || got_lut[40] != 204 || got_lut[50] != 255 || got_lut[59] != 255) begin
      n_fail++; $display("FAIL ovr_points: got %0d/%0d/%0d/%0d/%0d expected 51/153/204/255/255",
                         got_lut[10], got_lut[39], got_lut[40], got_lut[50], got_lut[59]);
    end
  endtask

  task automatic test_backpressure();
    int bad_seen, errs;
    push_ramp();
    run_frame(256, 1, 1'b0);
    bad_seen = 0; errs = 0;
    for (int b = 0; b < NB; b++) begin
      if (seen[b] != 1) bad_seen++;
      if (got_lut[b] != exp_lut[b]) errs++;
    end
    n_checks++;
    if (hist_to || out_to) begin n_fail++; $display("FAIL bp_timeout: hist %0d out %0d expected 0 0", hist_to, out_to); end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_err); end
    n_checks++;
    if (bad_seen != 0 || order_err != 0) begin n_fail++; $display("FAIL bp_addrs: got %0d bad counts %0d out of order expected 0 0", bad_seen, order_err); end
    n_checks++;
    if (last_err != 0) begin n_fail++; $display("FAIL bp_last: got %0d misplaced lut_last expected 0", last_err); end
    n_checks++;
    if (errs != 0 || got_lut[127] != 128 || done_cnt != 1) begin
      n_fail++; $display("FAIL bp_lut: got %0d diffs lut127=%0d done=%0d expected 0 128 1", errs, got_lut[127], done_cnt);
    end
  endtask

  task automatic test_reset_mid_hist();
    int w, errs;
    push_ramp();
    @(negedge clk); start = 1'b1; total_pix = CW'(256);
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!pix_ready && w < 400) begin @(negedge clk); w++; end
    for (int c = 0; c < 25; c++) begin
      pix_valid = sv_q.pop_front(); pix_data = sd_q.pop_front();
      @(negedge clk);
    end
    reset = 1'b1; pix_valid = '0;
    #1;
    n_checks++;
    if ({state, pix_ready, lut_valid, lut_last, done, busy, lut_addr, lut_data} !== {6'b000001, 21'd0}) begin
      n_fail++; $display("FAIL rst_mid: got st%b rdy%b v%b b%b expected st000001 all 0", state, pix_ready, lut_valid, busy);
    end
    @(negedge clk); reset = 1'b0;
    push_ramp();
    run_frame(256, 0, 1'b0);
    errs = 0;
    for (int b = 0; b < NB; b++) if (got_lut[b] != exp_lut[b]) errs++;
    n_checks++;
    if (hist_to || out_to || errs != 0 || got_lut[0] != 1 || got_lut[127] != 128 || got_lut[255] != 255 || done_cnt != 1) begin
      n_fail++; $display("FAIL rst_rerun: got %0d diffs lut0=%0d lut127=%0d done=%0d to=%0d/%0d expected 0 1 128 1 0/0",
                         errs, got_lut[0], got_lut[127], done_cnt, hist_to, out_to);
    end
  endtask

  task automatic test_ignored_start();
    int errs;
    logic [NCH*DW-1:0] cd;
    @(negedge clk); start = 1'b1; total_pix = '0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state !== 6'b000001 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_start: got st%b busy%b expected st000001 busy0", state, busy); end
    sv_q.delete(); sd_q.delete();
    for (int c = 0; c < 5; c++) begin cd = NCH*DW'($urandom); sv_q.push_back(2'b11); sd_q.push_back(cd); end
    run_frame(10, 0, 1'b1);
    n_checks++;
    if (cdf_state !== 6'b001000) begin n_fail++; $display("FAIL cdf_state: got %b expected 001000", cdf_state); end
    errs = 0;
    for (int b = 0; b < NB; b++) if (got_lut[b] != exp_lut[b]) errs++;
    n_checks++;
    if (hist_to || out_to || errs != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL cdf_start_lut: got %0d diffs done=%0d expected 0 1", errs, done_cnt);
    end
    n_checks++;
    if (state !== 6'b000001 || busy !== 1'b0) begin n_fail++; $display("FAIL cdf_start_idle: got st%b busy%b expected st000001 busy0", state, busy); end
  endtask

  task automatic test_random();
    int total, cum, exp_h, errs, bad_seen;
    logic [NCH-1:0] cv;
    logic [NCH*DW-1:0] cd;
    for (int f = 0; f < 3; f++) begin
      total = $urandom_range(1, 300);
      sv_q.delete(); sd_q.delete();
      cum = 0; exp_h = 0;
      while (cum < total) begin
        cv = NCH'($urandom);
        for (int k = 0; k < NCH; k++)
          cd[k*DW +: DW] = (f == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
        sv_q.push_back(cv); sd_q.push_back(cd);
        exp_h++;
        cum += $countones(cv);
      end
      for (int x = 0; x < 4; x++) begin sv_q.push_back('1); sd_q.push_back(NCH*DW'($urandom)); end
      run_frame(total, 2, 1'b0);
      errs = 0; bad_seen = 0;
      for (int b = 0; b < NB; b++) begin
        if (got_lut[b] != exp_lut[b]) errs++;
        if (seen[b] != 1) bad_seen++;
      end
      n_checks++;
      if (hist_to || out_to || hist_cycles != exp_h || latency != 769 + exp_h) begin
        n_fail++; $display("FAIL rnd%0d_timing: got cycles %0d latency %0d to %0d/%0d expected %0d %0d 0/0",
                           f, hist_cycles, latency, hist_to, out_to, exp_h, 769 + exp_h);
      end
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL rnd%0d_lut: got %0d differing entries expected 0 (total %0d)", f, errs, total); end
      n_checks++;
      if (bad_seen != 0 || stall_err != 0 || last_err != 0 || done_cnt != 1) begin
        n_fail++; $display("FAIL rnd%0d_stream: got seen %0d stall %0d last %0d done %0d expected 0 0 0 1",
                           f, bad_seen, stall_err, last_err, done_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; total_pix = '0;
    pix_valid = '0; pix_data = '0; lut_ready = 1'b0;
    test_reset();
    test_ramp();
    test_collision();
    test_overrun();
    test_backpressure();
    test_reset_mid_hist();
    test_ignored_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/he_lut_gen.md
Name: he_lut_gen

Overview:
Parametrised histogram-equalisation LUT generator, successor to the fixed 8-bit, two-pass HE calculator. It accepts NUM_CH pixel streams in parallel and takes a runtime total pixel count. It builds the histogram, CDF and equalisation map, then streams the NUM_BINS-entry LUT out over a valid/ready interface to the pixel-remap stage.

Parameters:
DWIDTH, 8, pixel bit width; NUM_BINS = 2**DWIDTH (derived, not overridable)
CWIDTH, 21, width of the pixel counter, histogram bins and CDF entries
NUM_CH, 2, number of parallel pixel input channels (1..4)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a frame; sampled in IDLE only
total_pix  input  CWIDTH  pixels in the frame; latched on the accepted start
pix_valid  input  NUM_CH  per-channel pixel valid
pix_data  input  NUM_CH*DWIDTH  channel k occupies bits [k*DWIDTH +: DWIDTH]
pix_ready  output  1  high only in HIST; pixels count only when pix_valid[k] && pix_ready
lut_valid  output  1  LUT entry available
lut_ready  input  1  downstream accepts the entry
lut_addr  output  DWIDTH  bin index of the current entry
lut_data  output  DWIDTH  equalised value for lut_addr
lut_last  output  1  high with the entry at lut_addr == NUM_BINS-1
done  output  1  one-cycle pulse after the last LUT handshake
busy  output  1  high in every state except IDLE
state  output  6  one-hot current state: IDLE, CLEAR, HIST, CDF, MAP, OUT (bits 0..5)

Behaviour:
- Reset, asynchronous: state=IDLE (6'b000001); pix_ready, lut_valid, lut_last, done and busy = 0; lut_addr and lut_data = 0; internal counters = 0. Reset mid-frame aborts the frame; array contents do not matter because CLEAR reinitialises them.
- IDLE: start=1 with total_pix!=0 latches total_pix and moves to CLEAR on the next edge. start with total_pix==0 is ignored. start in any other state is ignored.
- CLEAR: zeroes one histogram bin per cycle for NUM_BINS cycles, then moves to HIST.
- HIST: pix_ready=1. Each cycle, accepted pixels are taken from the valid channels in ascending index order, capped at the remaining count (total_pix - accepted). Excess pixels in the final cycle are dropped silently.
- HIST bin update: each bin is incremented by the number of accepted channels carrying that value, so same-bin collisions within a cycle are summed with no loss.
- HIST exit: when the accepted count reaches total_pix, move to CDF on the next edge. pix_ready deasserts that same edge.
- CDF: one entry per cycle, cdf[0]=hist[0] and cdf[i]=cdf[i-1]+hist[i], for NUM_BINS cycles, then MAP.
- MAP: one entry per cycle, lut[i] = (cdf[i]*(NUM_BINS-1) + (total_pix>>1)) / total_pix. Intermediates are CWIDTH+DWIDTH bits wide, the quotient is truncated, and the result is saturated to NUM_BINS-1. Runs for NUM_BINS cycles, then OUT.
- OUT: lut_valid=1 with lut_addr=0 on the first OUT cycle. On lut_valid && lut_ready, lut_addr increments and lut_data updates to the next entry on the next cycle. While lut_ready=0, lut_valid, lut_addr, lut_data and lut_last hold stable.
- OUT exit: the handshake with lut_last=1 deasserts lut_valid, pulses done for one cycle, and returns to IDLE. A new start is accepted the cycle after done.
- Latency from start to first lut_valid (DWIDTH=8): 1 + 256 (CLEAR) + HIST duration + 256 (CDF) + 256 (MAP) cycles.
- Counters never wrap: the pixel count saturates at total_pix. CDF fits in CWIDTH bits because it is bounded by total_pix.

Test Plan:
- Ramp (NUM_CH=2, total_pix=256): values 0..255 once each, 2 per cycle over 128 cycles -> lut[0]=1, lut[127]=128, lut[255]=255; 256 handshakes, then a single done pulse.
- Collision: total_pix=16, both channels send 100 in the same cycle for 8 cycles -> hist[100]=16, lut[0..99]=0, lut[100..255]=255.
- Overrun: total_pix=5, both channels valid with 10,20,30,40,50,60 over 3 cycles -> 60 (ch1, cycle 3) dropped; lut[50]=255, lut[59]=255, lut[40]=204; pix_ready low from the 4th cycle.
- Backpressure: lut_ready toggles 1,0,0,1 repeatedly -> lut_addr and lut_data hold while stalled; addresses 0..255 each seen exactly once; lut_last only at 255.
- Reset mid-HIST after 50 pixels -> all outputs zero and state=000001 immediately; rerun of the ramp frame gives results identical to scenario 1.
- Ignored start: start with total_pix=0 -> stays IDLE, busy=0; start pulsed during CDF -> no effect on the current frame's LUT.
